// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size encodings, FSM states and
// the byte-lane helpers used by both the stage and the memory wrapper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Reserved size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] w;
        w = data;
        case (size)
            SZ_BYTE: w = {4{data[7:0]}};
            SZ_HALF: w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_be.sv
// DEPTH x 32 memory with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module data_mem_be #(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: byte/half/word loads and stores, configurable read
// latency with a stall toward the hazard unit, registered outputs to WB.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | accepting a new instruction every cycle
//   WAIT    | load in flight; counter runs down, inputs held by upstream
module mem_stage_param
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 128,
    parameter int READ_LATENCY = 0,
    parameter int WB_W         = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Valid_In,
    input  logic [ADDR_W-1:0] Address_In,
    input  logic [31:0]       Data_In,
    input  logic              MemRead_In,
    input  logic              MemWrite_In,
    input  logic [1:0]        Size_In,
    input  logic              Unsigned_In,
    input  logic [WB_W-1:0]   WBControl_In,
    output logic              Stall_Out,
    output logic              Valid_Out,
    output logic [ADDR_W-1:0] Address_Out,
    output logic [31:0]       Data_Out,
    output logic [WB_W-1:0]   WBControl_Out,
    output logic              Misalign_Out
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [2:0] LAT   = 3'(READ_LATENCY);

    mem_state_t       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       lo;
    logic [IDX_W-1:0] word_idx;
    logic             misalign, do_write, do_read;
    logic [31:0]      rdata, load_data;
    logic             out_load, out_bubble;

    assign lo       = Address_In[1:0];
    assign word_idx = Address_In[IDX_W+1:2];
    assign misalign = Valid_In && (MemRead_In || MemWrite_In) && is_misaligned(Size_In, lo);
    // Write wins over a simultaneous read request.
    assign do_write = Valid_In && MemWrite_In && !misalign && (state_q == ST_IDLE);
    assign do_read  = Valid_In && MemRead_In && !MemWrite_In && !misalign;
    assign load_data = load_extract(rdata, Size_In, lo, Unsigned_In);

    data_mem_be #(.DEPTH(DEPTH)) u_dmem (
        .clk   (Clk),
        .we    (do_write),
        .be    (byte_enable(Size_In, lo)),
        .addr  (word_idx),
        .wdata (store_align(Data_In, Size_In)),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        Stall_Out  = 1'b0;
        out_load   = 1'b0;
        out_bubble = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (do_read && (READ_LATENCY > 0)) begin
                    state_d    = ST_WAIT;
                    cnt_d      = LAT;
                    Stall_Out  = 1'b1;
                    out_bubble = 1'b1;
                end else begin
                    out_load = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Last count: stall drops so upstream advances on the capture edge.
                if (cnt_q == 3'd1) begin
                    state_d  = ST_IDLE;
                    out_load = 1'b1;
                end else begin
                    Stall_Out = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Valid_Out     <= 1'b0;
            Address_Out   <= '0;
            Data_Out      <= 32'd0;
            WBControl_Out <= '0;
            Misalign_Out  <= 1'b0;
        end else if (out_bubble) begin
            Valid_Out     <= 1'b0;
            Address_Out   <= '0;
            Data_Out      <= 32'd0;
            WBControl_Out <= '0;
            Misalign_Out  <= 1'b0;
        end else if (out_load) begin
            Valid_Out     <= Valid_In;
            Address_Out   <= Address_In;
            Data_Out      <= do_read ? load_data : 32'd0;
            WBControl_Out <= Valid_In ? WBControl_In : '0;
            Misalign_Out  <= misalign;
        end
    end

    property p_hold_while_stalled;
        @(posedge Clk) disable iff (!Rst_n)
        Stall_Out |=> $stable({Valid_In, Address_In, Data_In, MemRead_In, MemWrite_In,
                               Size_In, Unsigned_In, WBControl_In});
    endproperty
    a_hold_while_stalled: assert property (p_hold_while_stalled);

endmodule

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
Parametrised MEM pipeline stage. It holds word-organised data memory and performs byte, half and word loads and stores with sign or zero extension. Read latency is configurable, and a stall handshake is raised to the hazard unit while a load waits. It sits between the EX/MEM and MEM/WB boundaries and registers address, load data, WB control and a misalignment flag toward WB.

Parameters:
ADDR_W, 32, width of Address_In/Address_Out
DEPTH, 128, number of 32-bit words in data memory (power of two)
READ_LATENCY, 0, extra cycles a load waits before data is captured (0..7)
WB_W, 2, width of the WB control bundle passed through

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
Valid_In  in  1  instruction present in MEM this cycle
Address_In  in  ADDR_W  byte address from ALU
Data_In  in  32  store data (rs2), right-aligned
MemRead_In  in  1  load request
MemWrite_In  in  1  store request
Size_In  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
Unsigned_In  in  1  1 = zero-extend load, 0 = sign-extend
WBControl_In  in  WB_W  WB control bundle
Stall_Out  out  1  high while a load is waiting; upstream must hold all inputs stable
Valid_Out  out  1  registered valid toward WB
Address_Out  out  ADDR_W  registered Address_In
Data_Out  out  32  registered, extended load data; 0 for non-loads
WBControl_Out  out  WB_W  registered WBControl_In; forced 0 when Valid_Out=0
Misalign_Out  out  1  registered misaligned-access flag

Behaviour:
- Reset (Rst_n low, async):
  - All outputs are 0 and the FSM is IDLE.
  - Memory contents are not cleared.
  - A reset during WAIT aborts the load; after release the stage is IDLE.
- Word index = Address_In[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. A misaligned access:
  - performs no write;
  - gives Data_Out=0 and Misalign_Out=1;
  - completes in one cycle with no stall.
- Read and write both high: the write wins, the read is ignored and Data_Out=0.
- Stores:
  - Byte lanes are selected by addr[1:0]/Size_In; only the enabled lanes are written, at the rising edge.
  - One-cycle completion; never stall.
- Loads:
  - Lane is extracted by addr[1:0] and extended per Unsigned_In.
  - Data_Out reflects memory as of that edge; a store in the previous cycle is visible.
- FSM states IDLE, WAIT:
  - IDLE, aligned load, READ_LATENCY=0: capture on this edge and stay in IDLE. Stall_Out is never asserted.
  - IDLE, aligned load, READ_LATENCY=N>0: go to WAIT, counter=N, Stall_Out=1 (combinational from the state and the request), output registers hold a bubble (Valid_Out=0).
  - WAIT: decrement the counter each edge. At counter=1, capture the load data into the outputs, drop Stall_Out, and return to IDLE. Total stall is N cycles; the result appears N+1 edges after issue.
  - Non-load or Valid_In=0: output registers load directly with no stall. Valid_In=0 produces a bubble: Valid_Out=0, WBControl_Out=0, Misalign_Out=0.
  - Inputs changing during WAIT are a protocol violation. Assertion: inputs stable while Stall_Out=1.
- Latency summary: a pass-through or store appears on the outputs one edge after being presented.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state typedef;
  - function for lane extract/extend;
  - function for byte-enable generation.
- One sub-module: data_mem_be (DEPTH x 32 array, 4 byte-enable write, asynchronous read). It is also reused for the instruction-side memory later.
- The stage keeps the FSM, counter and output register.

Test Plan:
1. READ_LATENCY=0:
   - SW 0xDEADBEEF to 0x10, then LW 0x10 → Data_Out=0xDEADBEEF one edge after the load, Stall_Out never high.
   - LB 0x13 signed → 0xFFFFFFDE.
   - LBU 0x13 → 0x000000DE.
2. SH 0x1234 to 0x22 over word 0x20=0 → word 0x20 = 0x12340000.
   - LH 0x22 → 0x00001234.
   - SB 0x80 to 0x21, then LH 0x20 signed → 0xFFFF8000.
3. Misaligned LW 0x06 and SH to 0x03 → Misalign_Out=1, Data_Out=0, memory unchanged (verified by a later aligned read).
4. READ_LATENCY=3, LW of 0xCAFEF00D → Stall_Out high exactly 3 cycles, Valid_Out=0 during the stall, data valid on the 4th edge. A back-to-back store issued afterwards executes once.
5. Address wrap, DEPTH=128: SW to 0x200 then LW 0x000 → same data returned.
6. Rst_n pulsed low mid-WAIT → outputs 0 immediately, FSM IDLE, Stall_Out=0. Previously stored memory contents are still readable after reset.
